dmem_bytelane: RTL

DMEM_BYTELANE -- requirements
Module: dmem_bytelane

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_load_ext.sv | 20 ++
 rtl/dmem_bytelane.sv | 74 +++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes and byte-enable helper for the byte-lane data memory
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    return size == 2'd0 ? 4'b0001 << lo : size == 2'd1 ? 4'b0011 << lo : 4'b1111;
  endfunction
endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: selects the addressed lane(s) of a word and sign/zero-extends
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lo,
  output logic [31:0] data
);
  logic [31:0] sh;
  // right-align the addressed lane, then extend by access size and signedness
  always_comb begin
    sh   = word >> {lo, 3'b000};
    data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
           funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
           funct3 == F3_W  ? word :
           funct3 == F3_BU ? {24'd0, sh[7:0]} :
           funct3 == F3_HU ? {16'd0, sh[15:0]} : '0;
  end
endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-lane data memory with RD_LAT-deep load pipeline; define DMEM_MISALIGN_CHK_EN to reject misaligned accesses
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  logic [RD_LAT-1:0] v, e;
  logic [31:0] d [RD_LAT];
  logic stall, acc, f3_bad, oor, mis, err;
  logic [1:0] lo;
  logic [AW-1:0] idx;
  logic [3:0] be;
  logic [31:0] wsh, ext;
  assign rsp_valid = v[RD_LAT-1];
  assign rsp_err   = e[RD_LAT-1];
  assign rsp_rdata = d[RD_LAT-1];
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !stall;
  assign acc       = req_valid && req_ready;
  // decode request: legality, natural-alignment lane offset, byte enables and lane-shifted store data
  always_comb begin
    f3_bad = req_we ? req_funct3 > F3_W : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    oor    = |(req_addr[ADDR_W-1:2] >> AW);
    lo     = req_funct3[1] ? 2'b00 : req_funct3[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
`ifdef DMEM_MISALIGN_CHK_EN
    mis    = lo != req_addr[1:0];
`else
    mis    = 1'b0;
`endif
    err    = f3_bad || oor || mis;
    idx    = req_addr[AW+1:2];
    be     = byte_en(req_funct3[1:0], lo);
    wsh    = req_wdata << {lo, 3'b000};
  end
  dmem_load_ext u_ext (.word(mem[idx]), .funct3(req_funct3), .lo(lo), .data(ext));
  // stores commit on their accept edge, only to enabled lanes
  always_ff @(posedge clk)
    if (acc && req_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
  // response shift chain: loads and rejected requests enter, the whole chain freezes under back-pressure
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else if (!stall) begin
      v[0] <= acc && (!req_we || err);
      e[0] <= acc && err;
      d[0] <= acc && !err && !req_we ? ext : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        d[i] <= d[i-1];
      end
    end
endmodule
